// File: rtl/cv32e40p_mult_iter.sv
// Iterative WIDTH x WIDTH multiplier built on one signed (SLICE+1)x(SLICE+1) slice multiplier.
// Optional build macro: MULT_ITER_ZERO_SKIP_EN (zero operand finishes in one cycle).
module cv32e40p_mult_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic [1:0]       signed_i,
    input  logic             hi_sel_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned ACCW   = 2 * WIDTH;
    localparam int unsigned PPW    = 2 * SLICE + 2;
    localparam int unsigned EXTW   = ACCW + PPW;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [1:0]        sgn_q;
    logic              hi_q;
    logic [ACCW-1:0]   acc_q;
    logic [IW-1:0]     i_q, j_q;
    logic              valid_q, ready_q, busy_q;
    logic [WIDTH-1:0]  result_q;

    logic [SLICE-1:0]       a_sl, b_sl;
    logic signed [SLICE:0]  a_s, b_s;
    logic signed [PPW-1:0]  pp;
    logic signed [EXTW-1:0] pp_wide;
    logic [31:0]            shamt;
    logic                   last_i, last_j;
    logic [ACCW-1:0]        acc_nxt;

    // Partial product of slices (i,j); only the top slice of a signed operand carries a sign bit
    always_comb begin
        a_sl    = SLICE'(a_q >> (32'(i_q) * SLICE));
        b_sl    = SLICE'(b_q >> (32'(j_q) * SLICE));
        last_i  = (i_q == IW'(NSLICE - 1));
        last_j  = (j_q == IW'(NSLICE - 1));
        a_s     = {sgn_q[0] & last_i & a_sl[SLICE-1], a_sl};
        b_s     = {sgn_q[1] & last_j & b_sl[SLICE-1], b_sl};
        pp      = a_s * b_s;
        pp_wide = EXTW'(pp);
        shamt   = (32'(i_q) + 32'(j_q)) * SLICE;
        acc_nxt = acc_q + ACCW'(pp_wide << shamt);
    end

    // Sequencer: IDLE -> BUSY (NSLICE^2 steps) -> DONE; kill returns to IDLE from anywhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= '0;
            hi_q     <= 1'b0;
            acc_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            result_q <= '0;
        end else if (kill_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i && ready_q) begin
                        a_q     <= op_a_i;
                        b_q     <= op_b_i;
                        sgn_q   <= signed_i;
                        hi_q    <= hi_sel_i;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        ready_q <= 1'b0;
`ifdef MULT_ITER_ZERO_SKIP_EN
                        if (op_a_i == '0 || op_b_i == '0) begin
                            state_q  <= S_DONE;
                            valid_q  <= 1'b1;
                            result_q <= '0;
                        end else begin
                            state_q <= S_BUSY;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= S_BUSY;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_nxt;
                    if (last_i && last_j) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        result_q <= hi_q ? acc_nxt[ACCW-1:WIDTH] : acc_nxt[WIDTH-1:0];
                    end else if (last_j) begin
                        j_q <= '0;
                        i_q <= i_q + IW'(1);
                    end else begin
                        j_q <= j_q + IW'(1);
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign busy_o   = busy_q;
    assign result_o = result_q;

endmodule
